// File: rtl/ffirst_buzzer_arbiter.sv
// Fastest-finger-first arbiter: synchronises and debounces active-low buttons,
// latches the first valid press of an armed round, with false-start masking and timeout.
module ffirst_buzzer_arbiter #(
  parameter int N_PLAYERS    = 10,
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 1000,
  localparam int IDX_W       = $clog2(N_PLAYERS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_PLAYERS-1:0] buzz_n,
  input  logic                 arm,
  input  logic                 clear,
  output logic                 winner_valid,
  output logic [IDX_W-1:0]     winner_idx,
  output logic [IDX_W-1:0]     winner_idx_n,
  output logic [N_PLAYERS-1:0] dq_mask,
  output logic                 armed,
  output logic                 timeout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_LOCKED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t               state_q;
  logic [N_PLAYERS-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0]     cnt_q [N_PLAYERS];
  logic [CNT_W-1:0]     cnt_d [N_PLAYERS];
  logic [N_PLAYERS-1:0] pr_s, pr_dly_q, ev_q, cand_s;
  logic [TMR_W-1:0]     timer_q;
  logic                 winner_valid_q, armed_q, timeout_q;
  logic [IDX_W-1:0]     winner_idx_q, winner_idx_n_q;
  logic [N_PLAYERS-1:0] dq_mask_q;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_PLAYERS-1:0] v);
    lowest_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  // Two-flop synchroniser; idle level is high (button released)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= buzz_n;
      sync2_q <= sync1_q;
    end
  end

  // Saturating run-length of synchronised low samples per channel
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      cnt_d[i] = cnt_q[i];
      pr_s[i]  = (cnt_q[i] == DEB_MAX);
      if (sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != DEB_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    cand_s = ev_q & ~dq_mask_q;
  end

  // Debounce counters and registered press-rise events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PLAYERS; i++) cnt_q[i] <= '0;
      pr_dly_q <= '0;
      ev_q     <= '0;
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) cnt_q[i] <= cnt_d[i];
      pr_dly_q <= pr_s;
      ev_q     <= pr_s & ~pr_dly_q;
    end
  end

  // Round state machine with registered outputs; clear overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      winner_valid_q <= 1'b0;
      winner_idx_q   <= '0;
      winner_idx_n_q <= '1;
      dq_mask_q      <= '0;
      armed_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else if (clear) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      winner_valid_q <= 1'b0;
      winner_idx_n_q <= '1;
      dq_mask_q      <= '0;
      armed_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_q   <= S_ARMED;
            dq_mask_q <= pr_s;
            timer_q   <= '0;
            armed_q   <= 1'b1;
          end
        end
        S_ARMED: begin
          // A press on the expiry cycle still wins
          if (cand_s != '0) begin
            state_q        <= S_LOCKED;
            winner_valid_q <= 1'b1;
            winner_idx_q   <= lowest_idx(cand_s);
            winner_idx_n_q <= ~lowest_idx(cand_s);
            armed_q        <= 1'b0;
          end else if (timer_q == TMR_LAST) begin
            state_q   <= S_TIMEOUT;
            armed_q   <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_LOCKED:  state_q <= S_LOCKED;
        S_TIMEOUT: state_q <= S_TIMEOUT;
        default: begin
          state_q        <= S_IDLE;
          winner_valid_q <= 1'b0;
          winner_idx_n_q <= '1;
          armed_q        <= 1'b0;
          timeout_q      <= 1'b0;
        end
      endcase
    end
  end

  assign winner_valid = winner_valid_q;
  assign winner_idx   = winner_idx_q;
  assign winner_idx_n = winner_idx_n_q;
  assign dq_mask      = dq_mask_q;
  assign armed        = armed_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_ffirst_buzzer_arbiter.sv
// Bench for ffirst_buzzer_arbiter: sample-history reference model feeds a scoreboard
// of expected winner/timeout events; a negedge monitor pops and compares.
module tb_ffirst_buzzer_arbiter;
  localparam int N  = 10;
  localparam int D  = 4;
  localparam int T  = 1000;
  localparam int IW = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_LOCKED = 2, M_TO = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  buzz_n = '1;
  logic          arm = 1'b0;
  logic          clear = 1'b0;
  logic          winner_valid;
  logic [IW-1:0] winner_idx, winner_idx_n;
  logic [N-1:0]  dq_mask;
  logic          armed, timeout;

  ffirst_buzzer_arbiter #(.N_PLAYERS(N), .DEBOUNCE_CYC(D), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .buzz_n(buzz_n), .arm(arm), .clear(clear),
    .winner_valid(winner_valid), .winner_idx(winner_idx), .winner_idx_n(winner_idx_n),
    .dq_mask(dq_mask), .armed(armed), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: rl_h[i][k] = consecutive raw low samples ending k+1 edges ago
  int            rl_h [N][4];
  int            m_state, m_timer, cyc;
  logic [N-1:0]  m_dq;
  logic          m_valid;
  logic [IW-1:0] m_idx;
  typedef struct { bit is_win; int idx; int cyc; } exp_t;
  exp_t          q[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 4; k++) rl_h[i][k] = 0;
    m_state = M_IDLE; m_timer = 0; m_dq = '0; m_valid = 1'b0; m_idx = '0;
    q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] held, evv, cand;
    int nrl, win;
    for (int i = 0; i < N; i++) begin
      held[i] = (rl_h[i][2] >= D);
      evv[i]  = (rl_h[i][3] == D);
      nrl = buzz_n[i] ? 0 : ((rl_h[i][0] + 1 > D + 1) ? D + 1 : rl_h[i][0] + 1);
      rl_h[i][3] = rl_h[i][2]; rl_h[i][2] = rl_h[i][1];
      rl_h[i][1] = rl_h[i][0]; rl_h[i][0] = nrl;
    end
    if (clear) begin
      m_state = M_IDLE; m_valid = 1'b0; m_dq = '0; m_timer = 0;
    end else if (m_state == M_IDLE) begin
      if (arm) begin m_state = M_ARMED; m_dq = held; m_timer = 0; end
    end else if (m_state == M_ARMED) begin
      cand = evv & ~m_dq;
      if (cand != '0) begin
        win = -1;
        for (int i = N - 1; i >= 0; i--) if (cand[i]) win = i;
        m_state = M_LOCKED; m_valid = 1'b1; m_idx = IW'(win);
        q.push_back('{1'b1, win, cyc});
      end else if (m_timer == T - 1) begin
        m_state = M_TO;
        q.push_back('{1'b0, 0, cyc});
      end else begin
        m_timer++;
      end
    end
    cyc++;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: full output tuple every cycle, plus scoreboard pop on winner/timeout rise
  logic prev_v = 1'b0, prev_t = 1'b0;
  initial begin
    logic [20:0] act, exp;
    exp_t e;
    forever begin
      @(negedge clk);
      act = {winner_valid, winner_idx, winner_idx_n, dq_mask, armed, timeout};
      exp = {m_valid, m_idx, (m_valid ? ~m_idx : 4'hF), m_dq,
             (m_state == M_ARMED), (m_state == M_TO)};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL outputs cyc=%0d: got %h expected %h", cyc, act, exp);
      end
      if ((winner_valid && !prev_v) || (timeout && !prev_t)) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL event cyc=%0d: got valid=%0b timeout=%0b expected no event",
                   cyc, winner_valid, timeout);
        end else begin
          e = q.pop_front();
          if (e.is_win != winner_valid || e.cyc != cyc - 1 ||
              (e.is_win && e.idx != int'(winner_idx))) begin
            fails++;
            $display("FAIL event: got win=%0b idx=%0d cyc=%0d expected win=%0b idx=%0d cyc=%0d",
                     winner_valid, winner_idx, cyc - 1, e.is_win, e.idx, e.cyc);
          end
        end
      end
      prev_v = winner_valid;
      prev_t = timeout;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      arm   = ($urandom_range(0, 59) == 0);
      clear = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 24) == 0) buzz_n[i] = ~buzz_n[i];
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    cyc_n(3); #1;
    chk("reset_outputs", {winner_valid, winner_idx, winner_idx_n, dq_mask, armed, timeout},
        {1'b0, 4'h0, 4'hF, 10'h000, 1'b0, 1'b0});
    @(posedge clk); #3 rst_n = 1'b1;
    cyc_n(4);

    // First press latency and lockout
    pulse_arm();
    #1 chk("arm_armed", armed, 1'b1);
    buzz_n[6] = 1'b0;
    cyc_n(7); #1 chk("latency_not_yet", winner_valid, 1'b0);
    cyc_n(1); #1 chk("latency_valid", winner_valid, 1'b1);
    chk("win6_idx", winner_idx, 4'd6);
    chk("win6_idx_n", winner_idx_n, 4'b1001);
    @(negedge clk); buzz_n[2] = 1'b0;
    cyc_n(12); #1 chk("lockout_idx", winner_idx, 4'd6);
    @(negedge clk); buzz_n = '1;
    cyc_n(6); pulse_clear(); cyc_n(8);

    // Same-edge tie
    pulse_arm();
    buzz_n[3] = 1'b0; buzz_n[8] = 1'b0;
    cyc_n(10); #1 chk("tie_idx", winner_idx, 4'd3);
    @(negedge clk); buzz_n = '1;
    cyc_n(6); pulse_clear(); cyc_n(8);

    // False start masking
    @(negedge clk); buzz_n[1] = 1'b0;
    cyc_n(10); pulse_arm();
    #1 chk("dq_mask", dq_mask, 10'h002);
    @(negedge clk); buzz_n[1] = 1'b1;
    cyc_n(6); buzz_n[1] = 1'b0;
    cyc_n(10); #1 chk("dq_repress_ignored", winner_valid, 1'b0);
    @(negedge clk); buzz_n[5] = 1'b0;
    cyc_n(10); #1 chk("dq_other_wins", winner_idx, 4'd5);
    @(negedge clk); buzz_n = '1;
    cyc_n(6); pulse_clear(); cyc_n(8);

    // Short glitch then timeout
    pulse_arm();
    buzz_n[4] = 1'b0; cyc_n(3); buzz_n[4] = 1'b1;
    cyc_n(20); #1 chk("glitch_no_win", winner_valid, 1'b0);
    cyc_n(990); #1 chk("timeout_set", {timeout, armed, winner_valid}, 3'b100);
    pulse_clear();
    #1 chk("timeout_cleared", timeout, 1'b0);
    cyc_n(4);

    // arm+clear collision, clear from LOCKED, re-arm
    @(negedge clk); arm = 1'b1; clear = 1'b1;
    @(negedge clk); arm = 1'b0; clear = 1'b0;
    #1 chk("arm_clear_idle", armed, 1'b0);
    pulse_arm();
    buzz_n[9] = 1'b0;
    cyc_n(10); #1 chk("win9_idx_n", winner_idx_n, 4'h6);
    pulse_clear();
    #1 chk("clear_outputs", {winner_valid, winner_idx_n, winner_idx}, {1'b0, 4'hF, 4'd9});
    @(negedge clk); buzz_n[9] = 1'b1;
    cyc_n(8); pulse_arm();
    buzz_n[2] = 1'b0;
    cyc_n(10); #1 chk("rearm_idx", winner_idx, 4'd2);
    @(negedge clk); buzz_n = '1;
    cyc_n(6); pulse_clear(); cyc_n(8);

    // Async reset mid-debounce
    pulse_arm();
    buzz_n[7] = 1'b0;
    cyc_n(4);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("midround_reset", {winner_valid, winner_idx, winner_idx_n, dq_mask, armed, timeout},
           {1'b0, 4'h0, 4'hF, 10'h000, 1'b0, 1'b0});
    cyc_n(2);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk); buzz_n[7] = 1'b1;
    cyc_n(20); #1 chk("no_win_after_reset", {winner_valid, armed}, 2'b00);

    // Random bouncing buttons with random arm/clear pulses
    rand_cycles(6000);
    @(negedge clk); arm = 1'b0; clear = 1'b1; buzz_n = '1;
    @(negedge clk); clear = 1'b0;
    cyc_n(10);
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
